imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Registered, parametrised immediate-extension stage for the MIPS decode->execute path.
//  Extends I_NBITS immediates to O_NBITS using a per-beat mode:
//    sign, zero, upper (LUI) or sign-extend-and-shift (branch offset).
//  Sits between the decoder and the ALU operand mux; stalls and flushes through a valid/ready handshake.
//  A 2-entry skid buffer keeps the input ready signal registered.
// PARAMETERS
//  I_NBITS   16  immediate input width
//  O_NBITS   32  extended output width; O_NBITS > I_NBITS + SHIFT_BR
//  SHIFT_BR   2  left shift applied in branch mode
//  CNT_NBITS  8  illegal-mode counter width (only with EXT_ERR_CNT_EN)
// PORTS
//  i_clk            in   1          clock, rising edge
//  i_reset          in   1          asynchronous reset, active-low
//  i_flush          in   1          synchronous pipeline flush (branch taken or exception)
//  i_signal         in   I_NBITS    immediate field
//  i_ExtensionMode  in   3          000 sign, 001 zero, 010 upper, 011 branch, others illegal
//  i_valid          in   1          input beat valid
//  o_ready          out  1          stage can accept a beat (registered)
//  o_ext_signal     out  O_NBITS    extended result
//  o_err            out  1          result came from an illegal mode (travels with the beat)
//  o_valid          out  1          output beat valid
//  i_ready          in   1          downstream accepts the output beat
//  o_err_cnt        out  CNT_NBITS  illegal-mode count (only with EXT_ERR_CNT_EN)
// BEHAVIOUR
//  Reset (i_reset=0, async): o_valid=0, skid empty, o_ready=1, o_ext_signal=0, o_err=0, o_err_cnt=0.
//  Extension (combinational on input, E = O_NBITS-I_NBITS):
//   000: {E{sign}, i_signal}
//   001: {E{0}, i_signal}
//   010: {i_signal, E{0}}
//   011: ({E{sign}, i_signal} << SHIFT_BR), truncated to O_NBITS, zero-filled LSBs
//   1xx: all ones ({O_NBITS{1}}), err=1
//  Handshake: accept = i_valid & o_ready; pop = o_valid & i_ready.
//   Beats are consumed only when accepted. Output holds stable while o_valid & !i_ready.
//  Storage: main reg M (drives outputs) and skid reg S; o_ready = !S.valid.
//   M empty or popped: M <= S if S valid (S then empties), else new beat if accepted, else M empties.
//   Accept while M valid and not popped: beat goes to S.
//   Accept and pop in same cycle with S empty: new beat goes straight to M.
//   Latency: 1 cycle accept->o_valid when stage empty.
//   Order is preserved; no beat is lost or duplicated; throughput 1 beat/cycle with i_ready=1.
//  Flush: i_flush=1 at an edge clears M.valid and S.valid.
//   A beat presented in the same cycle is discarded.
//   o_ready=1 the next cycle. Data registers are not cleared.
//  Data and err are captured only on accept; no enable on M when empty.
//   o_ext_signal keeps its last value while o_valid=0.
//  Reset asserted mid-operation: all beats dropped, outputs return to reset values immediately.
// CONFIGURATION
//  EXT_ERR_CNT_EN defined:
//   o_err_cnt increments by 1 per accepted illegal-mode beat, including flushed ones.
//   Saturates at all ones. Cleared only by reset.
//  EXT_ERR_CNT_EN undefined: o_err_cnt port and counter are absent; o_err still present.
// TESTING
//  Modes, I=16/O=32, i_ready=1:
//   0xAAAA mode 000 -> 0xFFFFAAAA; mode 001 -> 0x0000AAAA; mode 010 -> 0xAAAA0000.
//   0xFFFF mode 011 -> 0xFFFFFFFC; mode 101 -> 0xFFFFFFFF with o_err=1.
//   Each result appears with o_valid=1 exactly 1 cycle after accept.
//  Back-pressure:
//   Stream 0x0001,0x0002,0x0003 (mode 001) with i_ready=0 from cycle 1.
//   -> o_ready=0 after 2 beats held; 0x0003 is not accepted.
//   Release i_ready -> outputs 1,2,3 in order, no gaps after release.
//  Full-rate: 100 random beats, i_valid=i_ready=1.
//   -> o_valid continuous after 1st cycle; o_ready never drops; scoreboard matches.
//  Flush: M and S full, i_flush=1 with i_valid=1 (0x1234).
//   -> next cycle o_valid=0, o_ready=1; 0x1234 never appears.
//  Async reset: assert i_reset=0 between clock edges while o_valid=1.
//   -> o_valid=0 and o_ext_signal=0 before the next edge.
//  EXT_ERR_CNT_EN, CNT_NBITS=2: 5 accepted mode-111 beats -> o_err_cnt = 1,2,3,3,3.
//   Undefined: build has no o_err_cnt port.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage (sign / zero / upper / branch) with a 2-entry skid buffer.
// Optional illegal-mode counter enabled by defining EXT_ERR_CNT_EN.
module imm_ext_pipe #(
  parameter int I_NBITS  = 16,
  parameter int O_NBITS  = 32,
  parameter int SHIFT_BR = 2
`ifdef EXT_ERR_CNT_EN
  ,
  parameter int CNT_NBITS = 8
`endif
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic [I_NBITS-1:0] i_signal,
  input  logic [2:0]         i_ExtensionMode,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [O_NBITS-1:0] o_ext_signal,
  output logic               o_err,
  output logic               o_valid,
  input  logic               i_ready
`ifdef EXT_ERR_CNT_EN
  ,
  output logic [CNT_NBITS-1:0] o_err_cnt
`endif
);

  localparam int E = O_NBITS - I_NBITS;

  logic [O_NBITS-1:0] sext;
  logic [O_NBITS-1:0] ext_data;
  logic               ext_err;

  assign sext = {{E{i_signal[I_NBITS-1]}}, i_signal};

  always_comb begin
    ext_data = '1;
    ext_err  = 1'b0;
    case (i_ExtensionMode)
      3'b000:  ext_data = sext;
      3'b001:  ext_data = {{E{1'b0}}, i_signal};
      3'b010:  ext_data = {i_signal, {E{1'b0}}};
      3'b011:  ext_data = sext << SHIFT_BR;
      default: begin
        ext_data = '1;
        ext_err  = 1'b1;
      end
    endcase
  end

  // Valid/ready: a beat transfers on an edge where valid and ready are both high;
  // the producer holds its beat stable until that edge, the consumer never retracts ready on its own beat.
  logic               m_valid, s_valid;
  logic [O_NBITS-1:0] m_data, s_data;
  logic               m_err, s_err;
  logic               accept, pop;

  assign o_ready = ~s_valid;
  assign accept  = i_valid & o_ready;
  assign pop     = m_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      m_err   <= 1'b0;
      s_err   <= 1'b0;
    end else if (i_flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || pop) begin
      // Skid contents always drain before a new beat so ordering is kept.
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_err   <= s_err;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_data  <= ext_data;
        m_err   <= ext_err;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_data  <= ext_data;
      s_err   <= ext_err;
    end
  end

  assign o_valid      = m_valid;
  assign o_ext_signal = m_data;
  assign o_err        = m_err;

`ifdef EXT_ERR_CNT_EN
  // Counts every accepted illegal beat, flushed or not, saturating.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_err_cnt <= '0;
    end else if (accept && ext_err && (o_err_cnt != '1)) begin
      o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: modes, back-pressure, full rate, flush, async reset
// and, with EXT_ERR_CNT_EN defined, the saturating error counter.
module tb_imm_ext_pipe;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_flush = 1'b0;
  logic [15:0] i_signal = '0;
  logic [2:0]  i_ExtensionMode = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] o_ext_signal;
  logic        o_err;
  logic        o_valid;
  logic        i_ready = 1'b1;
`ifdef EXT_ERR_CNT_EN
  logic [1:0]  o_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  imm_ext_pipe #(
    .I_NBITS(16),
    .O_NBITS(32),
    .SHIFT_BR(2)
`ifdef EXT_ERR_CNT_EN
    ,
    .CNT_NBITS(2)
`endif
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_flush(i_flush),
    .i_signal(i_signal),
    .i_ExtensionMode(i_ExtensionMode),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_ext_signal(o_ext_signal),
    .o_err(o_err),
    .o_valid(o_valid),
    .i_ready(i_ready)
`ifdef EXT_ERR_CNT_EN
    ,
    .o_err_cnt(o_err_cnt)
`endif
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] sig, input logic [2:0] mode);
    i_valid         = 1'b1;
    i_signal        = sig;
    i_ExtensionMode = mode;
  endtask

  function automatic logic [32:0] model(input logic [15:0] s, input logic [2:0] m);
    logic signed [31:0] sx;
    sx = 32'($signed(s));
    case (m)
      3'd0:    model = {1'b0, sx};
      3'd1:    model = {1'b0, 32'(s)};
      3'd2:    model = {1'b0, 32'(s) * 32'd65536};
      3'd3:    model = {1'b0, sx * 32'sd4};
      default: model = {1'b1, 32'hFFFF_FFFF};
    endcase
  endfunction

  logic [15:0] v_sig [8] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hFFFF,
                             16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234};
  logic [2:0]  v_mode[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd3, 3'd0, 3'd7};
  logic [31:0] v_exp [8] = '{32'hFFFF_AAAA, 32'h0000_AAAA, 32'hAAAA_0000, 32'hFFFF_FFFC,
                             32'hFFFF_FFFF, 32'h0001_FFFC, 32'hFFFF_8000, 32'hFFFF_FFFF};
  logic        v_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int drops;
    logic [32:0] e;
    logic [15:0] rs;
    logic [2:0]  rm;

    // reset state
    #3;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_data", o_ext_signal, 32'h0);
    check("rst_err", 32'(o_err), 32'd0);
    #9 i_reset = 1'b1;
    tick();

    // extension modes streamed back-to-back, 1-cycle latency
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(v_sig[k], v_mode[k]);
      tick();
      check($sformatf("mode%0d_valid", k), 32'(o_valid), 32'd1);
      check($sformatf("mode%0d_data", k), o_ext_signal, v_exp[k]);
      check($sformatf("mode%0d_err", k), 32'(o_err), 32'(v_err[k]));
    end
    i_valid = 1'b0;
    tick();
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_hold_data", o_ext_signal, 32'hFFFF_FFFF);

    // back-pressure
    i_ready = 1'b0;
    drive(16'h0001, 3'd1);
    tick();
    check("bp1_ready", 32'(o_ready), 32'd1);
    drive(16'h0002, 3'd1);
    tick();
    check("bp2_ready", 32'(o_ready), 32'd0);
    drive(16'h0003, 3'd1);
    tick();
    check("bp3_ready", 32'(o_ready), 32'd0);
    check("bp3_hold", o_ext_signal, 32'h1);
    i_ready = 1'b1;
    tick();
    check("bp_out2_valid", 32'(o_valid), 32'd1);
    check("bp_out2", o_ext_signal, 32'h2);
    check("bp_ready_back", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
    check("bp_out3_valid", 32'(o_valid), 32'd1);
    check("bp_out3", o_ext_signal, 32'h3);
    tick();
    check("bp_drain", 32'(o_valid), 32'd0);

    // full rate random
    drops = 0;
    for (int k = 0; k < 100; k++) begin
      rs = 16'($urandom_range(0, 65535));
      rm = 3'($urandom_range(0, 7));
      drive(rs, rm);
      exp_q.push_back(model(rs, rm));
      tick();
      if (!o_ready) drops++;
      e = exp_q.pop_front();
      check("fr_valid", 32'(o_valid), 32'd1);
      check("fr_data", o_ext_signal, e[31:0]);
      check("fr_err", 32'(o_err), 32'(e[32]));
    end
    check("fr_ready_drops", 32'(drops), 32'd0);
    i_valid = 1'b0;
    tick();

    // flush with M and S full
    i_ready = 1'b0;
    drive(16'h0011, 3'd1);
    tick();
    drive(16'h0022, 3'd1);
    tick();
    check("fl_full_ready", 32'(o_ready), 32'd0);
    i_flush = 1'b1;
    drive(16'h1234, 3'd1);
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl_valid", 32'(o_valid), 32'd0);
    check("fl_ready", 32'(o_ready), 32'd1);
    check("fl_data_kept", o_ext_signal, 32'h11);
    i_ready = 1'b1;
    tick();
    check("fl_no_1234", 32'(o_valid), 32'd0);

    // flush with only M full and a beat the stage could accept
    i_ready = 1'b0;
    drive(16'h0033, 3'd1);
    tick();
    i_flush = 1'b1;
    drive(16'h1234, 3'd1);
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    check("fl2_valid", 32'(o_valid), 32'd0);
    tick();
    check("fl2_no_1234", 32'(o_valid), 32'd0);

    // async reset between edges
    drive(16'h00FF, 3'd1);
    tick();
    i_valid = 1'b0;
    check("ar_pre_valid", 32'(o_valid), 32'd1);
    #3 i_reset = 1'b0;
    #1;
    check("ar_valid", 32'(o_valid), 32'd0);
    check("ar_data", o_ext_signal, 32'h0);
    check("ar_ready", 32'(o_ready), 32'd1);
    #2 i_reset = 1'b1;
    tick();

`ifdef EXT_ERR_CNT_EN
    check("cnt_rst", 32'(o_err_cnt), 32'd0);
    for (int k = 0; k < 5; k++) begin
      drive(16'h5555, 3'd7);
      tick();
      check($sformatf("cnt_%0d", k), 32'(o_err_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    i_valid = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
